// File: rtl/btn_evt_pkg.sv
// Shared encodings for the button event controller: event kinds, per-button
// FSM states and a small constant helper.
package btn_evt_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_LONG    = 2'b01;
  localparam logic [1:0] EVT_REPEAT  = 2'b10;
  localparam logic [1:0] EVT_RELEASE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_fsm.sv
// One button: edge detect, millisecond hold counter, IDLE/PRESSED/HELD FSM and
// a single-entry pending slot that the top-level arbiter drains.
module button_event_fsm
  import btn_evt_pkg::*;
#(
  parameter int LONG_MS   = 500,
  parameter int REPEAT_MS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level,
  input  logic       tick,
  input  logic       grant,
  output logic       pend_valid,
  output logic [1:0] pend_kind,
  output logic       drop
);

  localparam int CW = $clog2(imax(LONG_MS, REPEAT_MS) + 1);

  btn_state_e    st;
  logic          btn_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          rise, fall;
  logic          emit;
  logic [1:0]    emit_kind;

  assign rise    = level & ~btn_q;
  assign fall    = ~level & btn_q;
  assign cnt_inc = (&cnt) ? cnt : cnt + CW'(1);

  // Fall is checked first so a release never also reports a threshold event.
  always_comb begin
    emit      = 1'b0;
    emit_kind = EVT_PRESS;
    case (st)
      ST_IDLE: if (rise) emit = 1'b1;
      ST_PRESSED:
        if (fall) begin
          emit      = 1'b1;
          emit_kind = EVT_RELEASE;
        end else if (tick && cnt_inc == CW'(LONG_MS)) begin
          emit      = 1'b1;
          emit_kind = EVT_LONG;
        end
      ST_HELD:
        if (fall) begin
          emit      = 1'b1;
          emit_kind = EVT_RELEASE;
        end else if (tick && cnt_inc == CW'(REPEAT_MS)) begin
          emit      = 1'b1;
          emit_kind = EVT_REPEAT;
        end
      default: ;
    endcase
  end

  assign drop = emit & pend_valid & ~grant;

  // btn_q resets high so a button held through reset must be released first.
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_IDLE;
      btn_q      <= 1'b1;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_kind  <= EVT_PRESS;
    end else begin
      btn_q <= level;
      case (st)
        ST_IDLE:
          if (rise) begin
            st  <= ST_PRESSED;
            cnt <= '0;
          end
        ST_PRESSED:
          if (fall) st <= ST_IDLE;
          else if (tick) begin
            if (cnt_inc == CW'(LONG_MS)) begin
              st  <= ST_HELD;
              cnt <= '0;
            end else cnt <= cnt_inc;
          end
        ST_HELD:
          if (fall) st <= ST_IDLE;
          else if (tick) begin
            if (cnt_inc == CW'(REPEAT_MS)) cnt <= '0;
            else cnt <= cnt_inc;
          end
        default: st <= ST_IDLE;
      endcase
      if (emit && !drop) begin
        pend_valid <= 1'b1;
        pend_kind  <= emit_kind;
      end else if (grant) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// N debounced buttons -> typed event stream. Per-button FSMs feed a round-robin
// arbiter into a small show-ahead FIFO drained over valid/ready.
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = 100000,
  parameter int LONG_MS    = 500,
  parameter int REPEAT_MS  = 100,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_db,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic [1:0]               evt_kind,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int IW   = $clog2(N_BTN);
  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    kind;
  } evt_t;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + TW'(1);
  end

  logic [N_BTN-1:0]      pend_valid, drop, grant;
  logic [N_BTN-1:0][1:0] pend_kind;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_event_fsm #(
      .LONG_MS   (LONG_MS),
      .REPEAT_MS (REPEAT_MS)
    ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .level      (btn_db[i]),
      .tick       (tick),
      .grant      (grant[i]),
      .pend_valid (pend_valid[i]),
      .pend_kind  (pend_kind[i]),
      .drop       (drop[i])
    );
  end

  logic [IW-1:0]   rr_ptr, gnt_idx;
  logic            gnt_any;
  logic            push, pop, full, can_accept;
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
  logic [CNTW-1:0] count, count_n;
  evt_t            mem [FIFO_DEPTH];
  evt_t            push_data, head_n;

  // First pending slot at or after rr_ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_BTN; k++) begin
      if (!gnt_any && pend_valid[(int'(rr_ptr) + k) % N_BTN]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'((int'(rr_ptr) + k) % N_BTN);
      end
    end
  end

  assign pop        = evt_valid & evt_ready;
  assign full       = (count == CNTW'(FIFO_DEPTH));
  assign can_accept = ~full | pop;
  assign push       = gnt_any & can_accept;
  assign grant      = push ? (N_BTN'(1) << gnt_idx) : '0;
  assign push_data  = evt_t'{gnt_idx, pend_kind[gnt_idx]};

  assign count_n  = count + CNTW'(push) - CNTW'(pop);
  assign rd_ptr_n = pop ? rd_ptr + AW'(1) : rd_ptr;
  // When the queue drains to nothing but this cycle's push, the head is the push.
  assign head_n   = (count == CNTW'(pop)) ? push_data : mem[rd_ptr_n];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_kind  <= EVT_PRESS;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (gnt_idx == IW'(N_BTN - 1)) ? '0 : gnt_idx + IW'(1);
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      evt_valid <= (count_n != '0);
      if (count_n != '0) begin
        evt_id   <= head_n.id;
        evt_kind <= head_n.kind;
      end
      if (|drop)             overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed scenarios plus random stimulus, checked every cycle against an
// event-level model (tick arithmetic, pending slots, RR, queue).
module tb_button_event_ctrl;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int LM = 3;
  localparam int RM = 2;
  localparam int D  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_db;
  logic         evt_valid, evt_ready;
  logic [1:0]   evt_id, evt_kind;
  logic         overflow, overflow_clr;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .N_BTN(N), .TICK_DIV(TD), .LONG_MS(LM), .REPEAT_MS(RM), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .btn_db(btn_db), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_id(evt_id), .evt_kind(evt_kind),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  int n_chk = 0, n_fail = 0;

  // model state
  int           kedge;
  logic [N-1:0] m_prev;
  bit           m_held [N];
  int           m_press[N];
  bit           m_pv   [N];
  int           m_pk   [N];
  int           m_rr;
  int           q[$];
  bit           m_ovf;
  int           last_id, last_kind;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  g, gk, t, kind;
    bit  tick, pop, can, e, any_drop;
    if (rst) begin
      kedge = 0; m_prev = '1; m_rr = 0; q.delete(); m_ovf = 0;
      last_id = 0; last_kind = 0;
      for (int b = 0; b < N; b++) begin m_held[b] = 0; m_pv[b] = 0; m_pk[b] = 0; end
      return;
    end
    kedge++;
    tick = (kedge % TD == 0);
    pop  = (q.size() > 0) && evt_ready;
    can  = (q.size() < D) || pop;
    g = -1; gk = 0;
    if (can)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pv[(m_rr + k) % N]) g = (m_rr + k) % N;
    if (g >= 0) gk = m_pk[g];
    any_drop = 0;
    for (int b = 0; b < N; b++) begin
      e = 0; kind = 0;
      if (btn_db[b] && !m_prev[b]) begin
        e = 1; kind = 0; m_held[b] = 1; m_press[b] = kedge;
      end else if (m_held[b] && !btn_db[b]) begin
        e = 1; kind = 3; m_held[b] = 0;
      end else if (m_held[b] && tick) begin
        // whole ticks elapsed since the press edge
        t = kedge / TD - m_press[b] / TD;
        if (t == LM) begin e = 1; kind = 1; end
        else if (t > LM && (t - LM) % RM == 0) begin e = 1; kind = 2; end
      end
      if (e) begin
        if (m_pv[b] && g != b) any_drop = 1;
        else begin m_pv[b] = 1; m_pk[b] = kind; end
      end else if (g == b) m_pv[b] = 0;
    end
    if (any_drop) m_ovf = 1;
    else if (overflow_clr) m_ovf = 0;
    if (pop) void'(q.pop_front());
    if (g >= 0) begin q.push_back(g * 4 + gk); m_rr = (g + 1) % N; end
    m_prev = btn_db;
    if (q.size() > 0) begin last_id = q[0] / 4; last_kind = q[0] % 4; end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      model_edge();
      @(posedge clk);
      @(negedge clk);
      chk("evt_valid", evt_valid, (q.size() > 0) ? 1 : 0);
      chk("evt_id",    evt_id,    last_id);
      chk("evt_kind",  evt_kind,  last_kind);
      chk("overflow",  overflow,  m_ovf);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; step(2); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn_db = '0; evt_ready = 1'b1; overflow_clr = 1'b0;
    @(negedge clk);
    do_reset();

    // short press on button 1
    btn_db = 4'b0010; step(6);
    btn_db = 4'b0000; step(6);

    // long hold on button 0: PRESS, LONG, REPEATs, RELEASE
    btn_db = 4'b0001; step(60);
    btn_db = 4'b0000; step(6);

    // simultaneous press from rr_ptr = 0
    do_reset();
    btn_db = 4'b1111; step(8);
    btn_db = 4'b0000; step(8);

    // fairness: after btn 2, btn 3 goes before btn 0
    btn_db = 4'b0100; step(4);
    btn_db = 4'b0000; step(4);
    btn_db = 4'b1001; step(6);
    btn_db = 4'b0000; step(6);

    // backpressure: six events into four FIFO slots plus one pending
    evt_ready = 1'b0;
    repeat (3) begin
      btn_db = 4'b0001; step(2);
      btn_db = 4'b0000; step(2);
    end
    chk("bp_overflow", overflow, 1);
    chk("bp_valid", evt_valid, 1);
    step(3);
    evt_ready = 1'b1; step(8);
    chk("bp_drained", evt_valid, 0);
    overflow_clr = 1'b1; step(1);
    overflow_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // reset while held: no PRESS until released and pressed again
    btn_db = 4'b0001; step(20);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("rst_valid", evt_valid, 0);
    step(10);
    chk("rst_no_press", evt_valid, 0);
    btn_db = 4'b0000; step(3);
    btn_db = 4'b0001; step(3);
    btn_db = 4'b0000; step(4);

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(11) == 0) btn_db[b] = ~btn_db[b];
      evt_ready    = ($urandom_range(3) != 0);
      overflow_clr = ($urandom_range(40) == 0);
      rst          = ($urandom_range(600) == 0);
      step(1);
    end
    rst = 1'b0; overflow_clr = 1'b0; evt_ready = 1'b1; btn_db = '0;
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Converts N debounced button levels into a queue of typed events: press, long-press, auto-repeat and release.
- Upstream is one debouncer per button, each providing a clean level on `btn_db[i]`.
- Downstream is the game/UI FSM, which consumes events over a valid/ready handshake.
- Round-robin arbitration shares the single event queue between buttons; a millisecond tick times long-press and repeat.

Parameters:
- N_BTN, 4, number of buttons.
- TICK_DIV, 100000, clk cycles per 1 ms tick (100 MHz).
- LONG_MS, 500, ticks held before a LONG event.
- REPEAT_MS, 100, ticks between REPEAT events while held after LONG.
- FIFO_DEPTH, 4, event queue entries (power of 2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- btn_db  in  N_BTN  debounced button levels, 1 = pressed
- evt_valid  out  1  queue head valid
- evt_ready  in  1  consumer accepts head
- evt_id  out  clog2(N_BTN)  button index of head event
- evt_kind  out  2  00 PRESS, 01 LONG, 10 REPEAT, 11 RELEASE
- overflow  out  1  sticky: an event was dropped
- overflow_clr  in  1  clears overflow

Behaviour:
- Reset (rst=1 at a clk edge): FSMs go to IDLE, counters 0, pending cleared, FIFO emptied, RR pointer 0. evt_valid=0, evt_id=0, evt_kind=0, overflow=0.
- Tick: free-running counter 0..TICK_DIV-1; `tick`=1 for one cycle when count==TICK_DIV-1.
- Edge detect: `btn_q<=btn_db`; rise=btn_db&~btn_q; fall=~btn_db&btn_q.
- Per-button FSM, states IDLE, PRESSED, HELD:
  - IDLE: on rise, emit PRESS, clear ms counter, go to PRESSED.
  - PRESSED: fall -> emit RELEASE, go to IDLE. Otherwise counter++ on tick; when it reaches LONG_MS, emit LONG, clear counter, go to HELD.
  - HELD: fall -> emit RELEASE, go to IDLE. Otherwise counter++ on tick; when it reaches REPEAT_MS, emit REPEAT and clear counter.
  - Fall has priority over a same-cycle threshold: only RELEASE is emitted.
  - Timing tolerance is ±1 ms, because the first tick is unaligned to the press.
- Pending slot: one entry per button (valid + kind), set on emit.
  - If an emit occurs while the slot is still occupied and not granted this cycle: the new event is dropped and overflow is set.
  - Grant and emit in the same cycle: the slot takes the new event.
- Arbiter:
  - Round-robin over pending slots, starting at rr_ptr.
  - At most one grant per cycle, and only if the FIFO can accept.
  - On grant: slot cleared, rr_ptr = granted index + 1 (mod N_BTN).
- FIFO:
  - Registered, show-ahead; the head is driven on evt_id/evt_kind.
  - Push on grant; pop on evt_valid&evt_ready.
  - Can accept = not full OR pop this cycle (push and pop in the same cycle when full are both taken).
  - Empty: evt_valid=0, outputs hold their last value.
  - Pointers wrap at FIFO_DEPTH.
  - Head must remain stable while evt_valid&~evt_ready.
- Latency: btn_db sampled 1 at edge t with empty FIFO and no competition -> pending at t+1 -> evt_valid=1 after edge t+2.
- overflow: sticky. overflow_clr clears it, but a same-cycle drop wins (stays 1).
- rst mid-hold: all state is lost. After rst, a button still held produces no PRESS until it has been observed released (btn_q reset to 1s, masking rise).
- Width rules:
  - ms counters are clog2(max(LONG_MS,REPEAT_MS)+1) bits and saturate, never wrap.
  - Tick counter is clog2(TICK_DIV) bits.

Decomposition:
- Package `btn_evt_pkg`:
  - EVT_PRESS/LONG/REPEAT/RELEASE 2-bit constants.
  - FSM state encodings IDLE/PRESSED/HELD.
- Sub-module `button_event_fsm`, instantiated N_BTN times:
  - Inputs: clk, rst, level, tick, grant.
  - Outputs: pend_valid, pend_kind, drop.
  - Contains the edge detect, ms counter, FSM and pending slot.
- Top level holds the tick divider, RR arbiter and FIFO.

Test Plan:
- Tests use TICK_DIV=4, LONG_MS=3, REPEAT_MS=2, evt_ready=1 unless stated.
- Short press: btn_db[1]=1 for 6 cycles, then 0 -> PRESS id=1 two cycles after rise; RELEASE id=1 two cycles after fall; no LONG.
- Long hold: btn_db[0]=1 for 60 cycles -> PRESS, LONG after ~12 cycles (±4), then REPEAT every 8 cycles, then RELEASE; order checked.
- Simultaneous: btn_db[3:0]=1111 at the same edge, rr_ptr=0 -> four PRESS events, ids 0,1,2,3, one per cycle.
- Fairness: press btn 2 only, then press btns 0 and 3 together -> rr_ptr=3 so the next order is id 3 then id 0.
- Backpressure/overflow: evt_ready=0; press/release btn0 three times -> FIFO holds 4 events, pending holds 1, overflow=1. Head stays stable. Raise evt_ready -> 5 events drain in order. Pulse overflow_clr -> overflow=0.
- Reset: rst=1 while btn_db[0] held in HELD -> evt_valid=0 next cycle, FIFO empty. Button still held -> no PRESS; release then press -> PRESS.
